// File: rtl/riscv_core_rf_pkg.sv
// Shared types and ABI constants for the multi-port integer register file.
package riscv_core_rf_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
  localparam reg_idx_t REG_SP   = reg_idx_t'(2);
  localparam reg_idx_t REG_GP   = reg_idx_t'(3);

  localparam logic [63:0] SP_INIT_DEF = 64'h0000_0000_7fff_fff0;
  localparam logic [63:0] GP_INIT_DEF = 64'h0000_0000_1000_0000;

endpackage

// File: rtl/riscv_core_rf_sb.sv
// Busy-bit scoreboard: one pending-writeback flag per architectural register.
module riscv_core_rf_sb
  import riscv_core_rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NWR   = 1,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NWR-1:0]          we_i,
  input  logic [NWR-1:0][AW-1:0]  wa_i,
  input  logic                    alloc_i,
  input  logic [AW-1:0]           alloc_a_i,
  input  logic                    flush_i,
  output logic [NREGS-1:0]        busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Order matters: clear, then set (alloc supersedes), then flush.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (we_i[k] && (wa_i[k] != '0)) begin
        busy_d[wa_i[k]] = 1'b0;
      end
    end
    if (alloc_i && (alloc_a_i != '0)) begin
      busy_d[alloc_a_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/riscv_core_rf_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
module riscv_core_rf_mp
  import riscv_core_rf_pkg::*;
#(
  parameter int unsigned     XLEN    = XLEN_DEF,
  parameter int unsigned     NREGS   = NREGS_DEF,
  parameter int unsigned     NRD     = 2,
  parameter int unsigned     NWR     = 1,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
  parameter logic [XLEN-1:0] GP_INIT = XLEN'(GP_INIT_DEF),
  localparam int unsigned    AW      = $clog2(NREGS)
) (
  input  logic                     i_rf_clk,
  input  logic                     i_rf_rst,
  input  logic [NRD-1:0][AW-1:0]   i_rf_ra,
  output logic [NRD-1:0][XLEN-1:0] o_rf_rd,
  output logic [NRD-1:0]           o_rf_busy,
  input  logic [NWR-1:0]           i_rf_we,
  input  logic [NWR-1:0][AW-1:0]   i_rf_wa,
  input  logic [NWR-1:0][XLEN-1:0] i_rf_wd,
  input  logic                     i_rf_alloc,
  input  logic [AW-1:0]            i_rf_alloc_a,
  input  logic                     i_rf_flush
);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [XLEN-1:0]  rf_d [NREGS];
  logic [NREGS-1:0] busy;
  logic [NWR-1:0]   wv;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wv[k] = i_rf_we[k] && (i_rf_wa[k] != '0);
    end
  end

  // Later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      rf_d[r] = rf_q[r];
    end
    for (int k = 0; k < NWR; k++) begin
      if (wv[k]) begin
        rf_d[i_rf_wa[k]] = i_rf_wd[k];
      end
    end
  end

  always_ff @(posedge i_rf_clk or posedge i_rf_rst) begin
    if (i_rf_rst) begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == int'(REG_SP)) begin
          rf_q[r] <= SP_INIT;
        end else if (r == int'(REG_GP)) begin
          rf_q[r] <= GP_INIT;
        end else begin
          rf_q[r] <= '0;
        end
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        rf_q[r] <= rf_d[r];
      end
      rf_q[0] <= '0;
    end
  end

  riscv_core_rf_sb #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk_i     (i_rf_clk),
    .rst_i     (i_rf_rst),
    .we_i      (i_rf_we),
    .wa_i      (i_rf_wa),
    .alloc_i   (i_rf_alloc),
    .alloc_a_i (i_rf_alloc_a),
    .flush_i   (i_rf_flush),
    .busy_o    (busy)
  );

  // A same-cycle writer supplies the data and hides the clearing busy bit.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      o_rf_rd[p]   = rf_q[i_rf_ra[p]];
      o_rf_busy[p] = busy[i_rf_ra[p]];
      for (int k = 0; k < NWR; k++) begin
        if (wv[k] && (i_rf_wa[k] == i_rf_ra[p])) begin
          o_rf_rd[p]   = i_rf_wd[k];
          o_rf_busy[p] = 1'b0;
        end
      end
      if (i_rf_ra[p] == '0) begin
        o_rf_rd[p]   = '0;
        o_rf_busy[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_rf_mp.sv
// Directed vector bench for riscv_core_rf_mp (NRD=2, NWR=2).
module tb_riscv_core_rf_mp;

  localparam logic [63:0] SP = 64'h0000_0000_7fff_fff0;
  localparam logic [63:0] GP = 64'h0000_0000_1000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][4:0]  ra;
  logic [1:0][63:0] rd;
  logic [1:0]       busy;
  logic [1:0]       we;
  logic [1:0][4:0]  wa;
  logic [1:0][63:0] wd;
  logic             alloc;
  logic [4:0]       alloc_a;
  logic             flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_core_rf_mp #(
    .NRD (2),
    .NWR (2)
  ) dut (
    .i_rf_clk     (clk),
    .i_rf_rst     (rst),
    .i_rf_ra      (ra),
    .o_rf_rd      (rd),
    .o_rf_busy    (busy),
    .i_rf_we      (we),
    .i_rf_wa      (wa),
    .i_rf_wd      (wd),
    .i_rf_alloc   (alloc),
    .i_rf_alloc_a (alloc_a),
    .i_rf_flush   (flush)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [63:0] wd0;
    logic [4:0]  wa1;
    logic [63:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        alloc;
    logic [4:0]  aa;
    logic        flush;
    logic [63:0] e0;
    logic [63:0] e1;
    logic        b0;
    logic        b1;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(
    logic [1:0] we_, logic [4:0] wa0_, logic [63:0] wd0_,
    logic [4:0] wa1_, logic [63:0] wd1_,
    logic [4:0] ra0_, logic [4:0] ra1_,
    logic al_, logic [4:0] aa_, logic fl_,
    logic [63:0] e0_, logic [63:0] e1_, logic b0_, logic b1_);
    vec_t v;
    v.we = we_; v.wa0 = wa0_; v.wd0 = wd0_;
    v.wa1 = wa1_; v.wd1 = wd1_;
    v.ra0 = ra0_; v.ra1 = ra1_;
    v.alloc = al_; v.aa = aa_; v.flush = fl_;
    v.e0 = e0_; v.e1 = e1_; v.b0 = b0_; v.b1 = b1_;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0;
    alloc = 1'b0; alloc_a = '0; flush = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(2'b01, 0, 64'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(2'b11, 7, 64'h11, 7, 64'h22, 7, 7, 0, 0, 0,
                 64'h22, 64'h22, 0, 0);
    tbl[4]  = mk(2'b00, 0, 0, 0, 0, 7, 5, 0, 0, 0, 64'h22, 0, 0, 0);
    tbl[5]  = mk(2'b00, 0, 0, 0, 0, 9, 7, 1, 9, 0, 0, 64'h22, 0, 0);
    tbl[6]  = mk(2'b00, 0, 0, 0, 0, 9, 2, 0, 0, 0, 0, SP, 1, 0);
    tbl[7]  = mk(2'b00, 0, 0, 0, 0, 9, 3, 0, 0, 0, 0, GP, 1, 0);
    tbl[8]  = mk(2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(2'b01, 9, 64'h5A, 0, 0, 9, 9, 0, 0, 0,
                 64'h5A, 64'h5A, 0, 0);
    tbl[10] = mk(2'b00, 0, 0, 0, 0, 9, 0, 0, 0, 0, 64'h5A, 0, 0, 0);
    tbl[11] = mk(2'b01, 4, 64'h3, 0, 0, 4, 9, 1, 4, 0,
                 64'h3, 64'h5A, 0, 0);
    tbl[12] = mk(2'b00, 0, 0, 0, 0, 4, 9, 0, 0, 0, 64'h3, 64'h5A, 1, 0);
    tbl[13] = mk(2'b00, 0, 0, 0, 0, 6, 4, 1, 6, 0, 0, 64'h3, 0, 1);
    tbl[14] = mk(2'b00, 0, 0, 0, 0, 6, 8, 1, 8, 0, 0, 0, 1, 0);
    tbl[15] = mk(2'b01, 12, 64'hC, 0, 0, 6, 8, 1, 10, 1, 0, 0, 1, 1);
    tbl[16] = mk(2'b00, 0, 0, 0, 0, 6, 8, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(2'b00, 0, 0, 0, 0, 10, 12, 0, 0, 0, 0, 64'hC, 0, 0);
    tbl[18] = mk(2'b10, 0, 0, 4, 64'h77, 4, 3, 0, 0, 0, 64'h77, GP, 0, 0);
    tbl[19] = mk(2'b00, 0, 0, 0, 0, 4, 2, 0, 0, 0, 64'h77, SP, 0, 0);

    rst = 1'b1;
    idle();
    ra[0] = 5'd2; ra[1] = 5'd3;
    #2;
    chk("rst_sp", rd[0], SP);
    chk("rst_gp", rd[1], GP);
    chk("rst_busy", {62'd0, busy}, 64'd0);

    @(negedge clk);
    rst = 1'b0;
    we = 2'b01; wa[0] = 5'd5; wd[0] = 64'hAB;
    alloc = 1'b1; alloc_a = 5'd6;
    @(negedge clk);
    idle();
    ra[0] = 5'd5; ra[1] = 5'd6;
    #1;
    chk("pre_x5", rd[0], 64'hAB);
    chk("pre_busy6", {63'd0, busy[1]}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_x5", rd[0], 64'd0);
    chk("mid_busy6", {63'd0, busy[1]}, 64'd0);
    ra[0] = 5'd2; ra[1] = 5'd3;
    #1;
    chk("mid_sp", rd[0], SP);
    chk("mid_gp", rd[1], GP);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we = tbl[i].we;
      wa[0] = tbl[i].wa0; wd[0] = tbl[i].wd0;
      wa[1] = tbl[i].wa1; wd[1] = tbl[i].wd1;
      ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1;
      alloc = tbl[i].alloc; alloc_a = tbl[i].aa;
      flush = tbl[i].flush;
      #1;
      chk($sformatf("v%0d_rd0", i), rd[0], tbl[i].e0);
      chk($sformatf("v%0d_rd1", i), rd[1], tbl[i].e1);
      chk($sformatf("v%0d_b0", i), {63'd0, busy[0]}, {63'd0, tbl[i].b0});
      chk($sformatf("v%0d_b1", i), {63'd0, busy[1]}, {63'd0, tbl[i].b1});
    end

    @(negedge clk);
    idle();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
